// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths, write-request type and address decode.
package regfile_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  localparam int REQ_W = REG_ADDR_W + XLEN;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wr_req_t;
  function automatic logic [NUM_REGS-1:0] dec(input logic [REG_ADDR_W-1:0] a);
    return NUM_REGS'(1) << a;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small ring-buffer FIFO of write requests with a decode mask of all held destinations.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  logic [REQ_W-1:0]    din,
  output logic [REQ_W-1:0]    head,
  output logic                full,
  output logic                empty,
  output logic [NUM_REGS-1:0] mask
);
  localparam logic [1:0] LAST = 2'(DEPTH - 1);
  wr_req_t mem_q [DEPTH];
  wr_req_t mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  assign full  = &vld_q;
  assign empty = ~|vld_q;
  always_comb begin
    mem_d  = mem_q;
    vld_d  = vld_q;
    head   = '0;
    mask   = '0;
    wptr_d = push ? (wptr_q == LAST ? 2'd0 : wptr_q + 2'd1) : wptr_q;
    rptr_d = pop ? (rptr_q == LAST ? 2'd0 : rptr_q + 2'd1) : rptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (rptr_q == 2'(i)) head = mem_q[i];
      if (pop && rptr_q == 2'(i)) vld_d[i] = 1'b0;
      if (push && wptr_q == 2'(i)) begin
        vld_d[i] = 1'b1;
        mem_d[i] = din;
      end
      if (vld_q[i]) mask = mask | dec(mem_q[i].addr);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '{default: '0};
      vld_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      mem_q  <= mem_d;
      vld_q  <= vld_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU and load writebacks into one registered register-file write port.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [XLEN-1:0]       a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [XLEN-1:0]       b_data,
  output logic                  rf_write,
  output logic [REG_ADDR_W-1:0] rf_daddress,
  output logic [XLEN-1:0]       rf_ddata,
  output logic [NUM_REGS-1:0]   pending,
  output logic                  idle
);
  wr_req_t a_head, b_head, wr;
  logic a_full, a_empty, b_full, b_empty;
  logic [NUM_REGS-1:0] a_mask, b_mask;
  logic en_q, prio_a_q, prio_a_d;
  logic rf_write_q, rf_write_d;
  logic [REG_ADDR_W-1:0] rf_daddress_q, rf_daddress_d;
  logic [XLEN-1:0] rf_ddata_q, rf_ddata_d;
  logic a_push, b_push, grant_a, grant_b;
  // en_q keeps both readies low until the first edge after reset release
  assign a_ready = en_q & ~a_full;
  assign b_ready = en_q & ~b_full;
  assign a_push  = a_valid & a_ready & (a_addr != '0);
  assign b_push  = b_valid & b_ready & (b_addr != '0);
  wb_fifo #(.DEPTH(DEPTH)) u_a_fifo (
    .clk(clk), .rst_n(rst_n), .push(a_push), .pop(grant_a), .din({a_addr, a_data}),
    .head(a_head), .full(a_full), .empty(a_empty), .mask(a_mask)
  );
  wb_fifo #(.DEPTH(DEPTH)) u_b_fifo (
    .clk(clk), .rst_n(rst_n), .push(b_push), .pop(grant_b), .din({b_addr, b_data}),
    .head(b_head), .full(b_full), .empty(b_empty), .mask(b_mask)
  );
  // tie priority only rotates when both heads actually contend
  always_comb begin
    grant_a       = ~a_empty & (b_empty | prio_a_q);
    grant_b       = ~b_empty & ~grant_a;
    prio_a_d      = (~a_empty & ~b_empty) ? grant_b : prio_a_q;
    wr            = grant_a ? a_head : b_head;
    rf_write_d    = grant_a | grant_b;
    rf_daddress_d = rf_write_d ? wr.addr : rf_daddress_q;
    rf_ddata_d    = rf_write_d ? wr.data : rf_ddata_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q          <= 1'b0;
      prio_a_q      <= 1'b1;
      rf_write_q    <= 1'b0;
      rf_daddress_q <= '0;
      rf_ddata_q    <= '0;
    end else begin
      en_q          <= 1'b1;
      prio_a_q      <= prio_a_d;
      rf_write_q    <= rf_write_d;
      rf_daddress_q <= rf_daddress_d;
      rf_ddata_q    <= rf_ddata_d;
    end
  end
  assign rf_write    = rf_write_q;
  assign rf_daddress = rf_daddress_q;
  assign rf_ddata    = rf_ddata_q;
  assign pending     = (a_mask | b_mask | (rf_write_q ? dec(rf_daddress_q) : '0)) & ~NUM_REGS'(1);
  assign idle        = a_empty & b_empty & ~rf_write_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed writeback-arbiter vectors with hand-computed expectations.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic a_valid = 1'b0, b_valid = 1'b0;
  logic a_ready, b_ready, rf_write, idle;
  logic [4:0] a_addr = '0, b_addr = '0, rf_daddress;
  logic [31:0] a_data = '0, b_data = '0, rf_ddata, pending;
  int n_vec = 0, n_err = 0;

  regfile_wb_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_write(rf_write), .rf_daddress(rf_daddress), .rf_ddata(rf_ddata),
    .pending(pending), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] ad, input logic [31:0] d);
    chk({tag, ".wr"}, 32'(rf_write), 32'd1);
    chk({tag, ".addr"}, 32'(rf_daddress), 32'(ad));
    chk({tag, ".data"}, rf_ddata, d);
  endtask

  initial begin
    #3;
    chk("rst.a_ready", 32'(a_ready), 32'd0);
    chk("rst.b_ready", 32'(b_ready), 32'd0);
    chk("rst.pending", pending, 32'd0);
    chk("rst.idle", 32'(idle), 32'd1);
    chk("rst.rf_write", 32'(rf_write), 32'd0);
    step();
    rst_n = 1'b1;
    chk("rel.a_ready_low", 32'(a_ready), 32'd0);
    step();
    chk("rel.a_ready", 32'(a_ready), 32'd1);
    chk("rel.b_ready", 32'(b_ready), 32'd1);

    // single write
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    step();
    a_valid = 1'b0;
    chk("single.wr0", 32'(rf_write), 32'd0);
    chk("single.pend1", pending, 32'h20);
    chk("single.idle0", 32'(idle), 32'd0);
    step();
    chk_wr("single", 5'd5, 32'hDEADBEEF);
    chk("single.pend2", pending, 32'h20);
    step();
    chk("single.wr_off", 32'(rf_write), 32'd0);
    chk("single.addr_hold", 32'(rf_daddress), 32'd5);
    chk("single.pend3", pending, 32'd0);
    chk("single.idle", 32'(idle), 32'd1);

    // contention, then round-robin on the repeat
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h22;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("cont1.pend", pending, 32'h18);
    step();
    chk_wr("cont1.first", 5'd3, 32'h11);
    step();
    chk_wr("cont1.second", 5'd4, 32'h22);
    step();
    chk("cont1.done", 32'(rf_write), 32'd0);
    a_valid = 1'b1; b_valid = 1'b1;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    chk_wr("cont2.first", 5'd4, 32'h22);
    step();
    chk_wr("cont2.second", 5'd3, 32'h11);
    step();
    chk("cont2.idle", 32'(idle), 32'd1);

    // x0 discard
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFFFFFF;
    chk("x0.ready", 32'(a_ready), 32'd1);
    step();
    a_valid = 1'b0;
    chk("x0.pend", pending, 32'd0);
    chk("x0.idle", 32'(idle), 32'd1);
    step();
    chk("x0.wr", 32'(rf_write), 32'd0);
    chk("x0.idle2", 32'(idle), 32'd1);

    // B alone, three writes in order
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h70;
    step();
    b_addr = 5'd8; b_data = 32'h80;
    step();
    chk_wr("bseq.7", 5'd7, 32'h70);
    b_addr = 5'd9; b_data = 32'h90;
    chk("bseq.ready", 32'(b_ready), 32'd1);
    step();
    b_valid = 1'b0;
    chk_wr("bseq.8", 5'd8, 32'h80);
    step();
    chk_wr("bseq.9", 5'd9, 32'h90);
    step();
    chk("bseq.idle", 32'(idle), 32'd1);

    // back-pressure with both requesters streaming
    a_valid = 1'b1; a_addr = 5'd10; a_data = 32'hA0;
    b_valid = 1'b1; b_addr = 5'd20; b_data = 32'hB0;
    step();
    a_addr = 5'd11; a_data = 32'hA1; b_addr = 5'd21; b_data = 32'hB1;
    step();
    chk_wr("bp.a10", 5'd10, 32'hA0);
    chk("bp.b_full", 32'(b_ready), 32'd0);
    chk("bp.a_ok", 32'(a_ready), 32'd1);
    a_addr = 5'd12; a_data = 32'hA2; b_addr = 5'd22; b_data = 32'hB2;
    step();
    chk_wr("bp.b20", 5'd20, 32'hB0);
    chk("bp.a_full", 32'(a_ready), 32'd0);
    chk("bp.b_ok", 32'(b_ready), 32'd1);
    chk("bp.pend", pending, 32'h00301800 | 32'h00100000);
    a_valid = 1'b0;
    step();
    b_valid = 1'b0;
    chk_wr("bp.a11", 5'd11, 32'hA1);
    step();
    chk_wr("bp.b21", 5'd21, 32'hB1);
    step();
    chk_wr("bp.a12", 5'd12, 32'hA2);
    step();
    chk_wr("bp.b22", 5'd22, 32'hB2);
    step();
    chk("bp.idle", 32'(idle), 32'd1);

    // reset mid-stream
    a_valid = 1'b1; a_addr = 5'd13; a_data = 32'hC0;
    b_valid = 1'b1; b_addr = 5'd14; b_data = 32'hD0;
    step();
    a_addr = 5'd15; b_addr = 5'd16;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    chk_wr("mid.b14", 5'd14, 32'hD0);
    chk("mid.a_full", 32'(a_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid.wr0", 32'(rf_write), 32'd0);
    chk("mid.addr0", 32'(rf_daddress), 32'd0);
    chk("mid.pend0", pending, 32'd0);
    chk("mid.idle", 32'(idle), 32'd1);
    chk("mid.b_ready", 32'(b_ready), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("mid.post_wr1", 32'(rf_write), 32'd0);
    chk("mid.post_ready", 32'(a_ready), 32'd1);
    step();
    chk("mid.post_wr2", 32'(rf_write), 32'd0);
    chk("mid.post_idle", 32'(idle), 32'd1);

    // streaming eight writes from A
    for (int i = 1; i <= 8; i++) begin
      a_valid = 1'b1; a_addr = 5'(i); a_data = 32'(i) << 8;
      step();
      if (i > 1) chk_wr("stream", 5'(i - 1), 32'(i - 1) << 8);
    end
    a_valid = 1'b0;
    step();
    chk_wr("stream.last", 5'd8, 32'h800);
    step();
    chk("stream.end", 32'(rf_write), 32'd0);
    chk("stream.idle", 32'(idle), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
